// File: rtl/cargador_serial.sv
// Bit-serial operand loader for red_iterativa: shifts A/B in LSB first,
// presents the words for one settle cycle, then captures N/Z and pulses done.
module cargador_serial #(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         bit_valid,
    input  logic         a_in,
    input  logic         b_in,
    output logic [K-1:0] A_out,
    output logic [K-1:0] B_out,
    input  logic [K-1:0] N_in,
    input  logic         Z_in,
    output logic [K-1:0] N_res,
    output logic         Z_res,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(K + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [K-1:0]  a_sh;
    logic [K-1:0]  b_sh;
    logic [CW-1:0] cnt;
    logic          last_bit;

    assign last_bit = (cnt == CW'(K - 1));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD:    if (bit_valid && last_bit) state_n = PRESENT;
            PRESENT: state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            N_res <= '0;
            Z_res <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh <= '0;
                        b_sh <= '0;
                        cnt  <= '0;
                    end
                end
                LOAD: begin
                    if (bit_valid) begin
                        a_sh <= {a_in, a_sh[K-1:1]};
                        b_sh <= {b_in, b_sh[K-1:1]};
                        cnt  <= cnt + CW'(1);
                    end
                end
                // Words have been stable for a full cycle; network is settled.
                PRESENT: begin
                    N_res <= N_in;
                    Z_res <= Z_in;
                end
                default: ;
            endcase
        end
    end

    assign A_out = a_sh;
    assign B_out = b_sh;
    assign busy  = (state == LOAD) || (state == PRESENT);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_cargador_serial.sv
// Directed bench for cargador_serial; a small stand-in network drives
// N_in = A ^ B and Z_in = |(A & B) from the presented words.
module tb_cargador_serial;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       bit_valid;
    logic       a_in;
    logic       b_in;
    logic [3:0] A_out;
    logic [3:0] B_out;
    logic [3:0] N_in;
    logic       Z_in;
    logic [3:0] N_res;
    logic       Z_res;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    int         lat;
    int         bcnt;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [3:0] npre;
    logic       zpre;

    always #5 clk = ~clk;

    assign N_in = A_out ^ B_out;
    assign Z_in = |(A_out & B_out);

    cargador_serial #(.K(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bit_valid (bit_valid),
        .a_in      (a_in),
        .b_in      (b_in),
        .A_out     (A_out),
        .B_out     (B_out),
        .N_in      (N_in),
        .Z_in      (Z_in),
        .N_res     (N_res),
        .Z_res     (Z_res),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (busy) bcnt++;
        lat++;
    endtask

    // Runs one operation; inputs change on negedges, outputs sampled there too.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b,
                         input int gap_after, input int gap_len,
                         input bit mid_start, input bit start_at_done);
        int n;
        lat  = -1;
        bcnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == gap_after) begin
                bit_valid = 1'b0;
                repeat (gap_len) tick();
            end
            bit_valid = 1'b1;
            a_in = a[i];
            b_in = b[i];
            if (mid_start && i == 1) start = 1'b1;
            tick();
            start = 1'b0;
        end
        bit_valid = 1'b0;
        a4   = A_out;
        b4   = B_out;
        npre = N_res;
        zpre = Z_res;
        n = 0;
        while (!done && n < 12) begin
            tick();
            n++;
        end
        if (!done) lat = 99;
        if (start_at_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        bit_valid = 1'b1;
        a_in = 1'b1;
        b_in = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        bit_valid = 1'b0;
        chk("rst_a", {4'b0, A_out}, 8'h00);
        chk("rst_b", {4'b0, B_out}, 8'h00);
        chk("rst_n", {4'b0, N_res}, 8'h00);
        chk("rst_z", {7'b0, Z_res}, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_done", {7'b0, done}, 8'h00);
        @(negedge clk);
        chk("rst_idle", {7'b0, busy}, 8'h00);

        do_op(4'b1010, 4'b0110, 9, 0, 1'b0, 1'b0);
        chk("nom_a4", {4'b0, a4}, 8'h0A);
        chk("nom_b4", {4'b0, b4}, 8'h06);
        chk("nom_npre", {4'b0, npre}, 8'h00);
        chk("nom_lat", 8'(lat), 8'd5);
        chk("nom_busy", 8'(bcnt), 8'd5);
        chk("nom_n", {4'b0, N_res}, 8'h0C);
        chk("nom_z", {7'b0, Z_res}, 8'h01);
        chk("nom_idle", {6'b0, busy, done}, 8'h00);
        chk("nom_hold_a", {4'b0, A_out}, 8'h0A);

        do_op(4'b1010, 4'b0110, 2, 2, 1'b0, 1'b0);
        chk("gap_a", {4'b0, a4}, 8'h0A);
        chk("gap_b", {4'b0, b4}, 8'h06);
        chk("gap_lat", 8'(lat), 8'd7);
        chk("gap_n", {4'b0, N_res}, 8'h0C);

        do_op(4'b0011, 4'b0101, 9, 0, 1'b1, 1'b1);
        chk("ign_a", {4'b0, a4}, 8'h03);
        chk("ign_lat", 8'(lat), 8'd5);
        chk("ign_n", {4'b0, N_res}, 8'h06);
        chk("ign_z", {7'b0, Z_res}, 8'h01);
        chk("ign_idle", {6'b0, busy, done}, 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("ign_norestart", {6'b0, busy, done}, 8'h00);
        end
        chk("ign_hold_a", {4'b0, A_out}, 8'h03);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bit_valid = 1'b1;
        a_in = 1'b1;
        b_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_part_a", {4'b0, A_out}, 8'h0C);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bit_valid = 1'b0;
        chk("mid_a", {4'b0, A_out}, 8'h00);
        chk("mid_b", {4'b0, B_out}, 8'h00);
        chk("mid_n", {4'b0, N_res}, 8'h00);
        chk("mid_z", {7'b0, Z_res}, 8'h00);
        chk("mid_bd", {6'b0, busy, done}, 8'h00);
        repeat (4) begin
            @(negedge clk);
            chk("mid_nodone", {6'b0, busy, done}, 8'h00);
        end
        do_op(4'b1010, 4'b0110, 9, 0, 1'b0, 1'b0);
        chk("mid_fresh_lat", 8'(lat), 8'd5);
        chk("mid_fresh_n", {3'b0, Z_res, N_res}, 8'h1C);

        do_op(4'b0000, 4'b0000, 9, 0, 1'b0, 1'b0);
        chk("b2b0_pre", {3'b0, zpre, npre}, 8'h1C);
        chk("b2b0_res", {3'b0, Z_res, N_res}, 8'h00);
        do_op(4'b1111, 4'b0001, 9, 0, 1'b0, 1'b0);
        chk("b2b1_pre", {3'b0, zpre, npre}, 8'h00);
        chk("b2b1_ab", {a4, b4}, 8'hF1);
        chk("b2b1_res", {3'b0, Z_res, N_res}, 8'h1E);
        do_op(4'b0101, 4'b1010, 9, 0, 1'b0, 1'b0);
        chk("b2b2_pre", {3'b0, zpre, npre}, 8'h1E);
        chk("b2b2_ab", {a4, b4}, 8'h5A);
        chk("b2b2_res", {3'b0, Z_res, N_res}, 8'h0F);
        chk("b2b2_lat", 8'(lat), 8'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
